// File: rtl/uart_tx_io.sv
// rtl/uart_tx_io.sv - memory-mapped 8N1 UART transmitter with a small transmit FIFO
module uart_tx_io #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 8,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr_ovf,
    output logic          tx,
    output logic          busy,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_reg;
    logic          ovf_reg;
    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          tx_reg;

    logic full_int;
    logic empty_int;
    logic wr_accept;
    logic pop;
    logic baud_end;

    assign full_int  = (count_reg == CW'(FIFO_DEPTH));
    assign empty_int = (count_reg == '0);
    // Acceptance and pop are both judged on the pre-edge count.
    assign wr_accept = wr_en && !full_int;
    assign pop       = (state == IDLE) && !empty_int;
    assign baud_end  = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_accept, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase

            // A dropped write outranks a same-cycle clear.
            if (wr_en && full_int) begin
                ovf_reg <= 1'b1;
            end else if (clr_ovf) begin
                ovf_reg <= 1'b0;
            end

            case (state)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        tx_reg    <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_reg   <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            tx_reg <= 1'b1;
                            state  <= STOP;
                        end else begin
                            tx_reg <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
            endcase
        end
    end

    assign tx       = tx_reg;
    assign busy     = (state != IDLE) || !empty_int;
    assign full     = full_int;
    assign empty    = empty_int;
    assign overflow = ovf_reg;
    assign count    = count_reg;

endmodule

// File: tb/tb_uart_tx_io.sv
// tb/tb_uart_tx_io.sv - directed self-checking bench for uart_tx_io
module tb_uart_tx_io;

    localparam int CPB = 4;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          clr_ovf = 1'b0;
    logic          tx;
    logic          busy;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q[$];
    int         st_q[$];
    int         frame_err = 0;

    uart_tx_io #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
        .tx(tx), .busy(busy), .full(full), .empty(empty), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    // Line receiver: samples mid-bit on the falling edge, logs bytes and start cycles.
    initial begin : monitor
        int cyc;
        int pos;
        bit in_frame;
        logic [9:0] bits;
        cyc = 0; pos = 0; in_frame = 1'b0; bits = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && tx === 1'b0) begin
                    in_frame = 1'b1;
                    pos = 0;
                    st_q.push_back(cyc);
                end
                if (in_frame) begin
                    if (pos % CPB == CPB / 2) bits[pos / CPB] = tx;
                    if (pos == 10 * CPB - 1) begin
                        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_err++;
                        rx_q.push_back(bits[8:1]);
                        in_frame = 1'b0;
                    end
                    pos++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    endtask

    task automatic test_single();
        logic [9:0] line;
        line = {1'b1, 8'hA5, 1'b0};
        rx_q.delete(); st_q.delete();
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_pre: got %b expected 1", tx); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_pre: got %b expected 1", busy); end
        tick();
        for (int i = 0; i < 10 * CPB; i++) begin
            checks++; if (tx !== line[i / CPB]) begin errors++; $display("FAIL single_line cycle %0d: got %b expected %b", i, tx, line[i / CPB]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy cycle %0d: got %b expected 1", i, busy); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_end: got %b expected 1", empty); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin errors++; $display("FAIL single_rx: got %0d bytes first %h expected 1 byte a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        bit ok;
        exp_b = '{8'h00, 8'hFF, 8'h3C};
        rx_q.delete(); st_q.delete();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = exp_b[i];
            tick();
        end
        wr_en = 1'b0;
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL b2b_count_peak: got %0d expected 2", count); end
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: busy still %b expected 0", busy); end
        checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL b2b_frames: got %0d expected 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]); end
        end
        for (int i = 1; i < 3 && i < st_q.size(); i++) begin
            checks++; if (st_q[i] - st_q[i-1] != 10 * CPB + 1) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, st_q[i] - st_q[i-1], 10 * CPB + 1); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", empty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", busy); end
    endtask

    task automatic test_overflow();
        bit ok;
        rx_q.delete(); st_q.delete();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        wait_idle(500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: busy still %b expected 0", busy); end
        checks++; if (rx_q.size() != 9) begin errors++; $display("FAIL ovf_frames: got %0d expected 9", rx_q.size()); end
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL ovf_byte%0d: got %h expected %h", i, rx_q[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_collision();
        bit ok;
        rx_q.delete(); st_q.delete();
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_data = 8'hC3;
        tick();
        wr_en = 1'b0;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL coll_count: got %0d expected 1", count); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL coll_start: got %b expected 0", tx); end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL coll_timeout: busy still %b expected 0", busy); end
        checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL coll_frames: got %0d expected 2", rx_q.size()); end
        checks++; if (rx_q.size() > 0 && rx_q[0] !== 8'h5A) begin errors++; $display("FAIL coll_byte0: got %h expected 5a", rx_q[0]); end
        checks++; if (rx_q.size() > 1 && rx_q[1] !== 8'hC3) begin errors++; $display("FAIL coll_byte1: got %h expected c3", rx_q[1]); end
    endtask

    task automatic test_full_pop();
        bit ok;
        rx_q.delete(); st_q.delete();
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        repeat (33) tick();
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fp_count_pre: got %0d expected 8", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_ovf_pre: got %b expected 0", overflow); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL fp_idle_tx: got %b expected 1", tx); end
        wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL fp_count: got %0d expected 7", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fp_ovf: got %b expected 1", overflow); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL fp_start: got %b expected 0", tx); end
        wait_idle(500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fp_timeout: busy still %b expected 0", busy); end
        checks++; if (rx_q.size() != 9) begin errors++; $display("FAIL fp_frames: got %0d expected 9", rx_q.size()); end
        checks++; if (rx_q.size() == 9 && rx_q[8] !== 8'h18) begin errors++; $display("FAIL fp_last: got %h expected 18", rx_q[8]); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'hF0;
            tick();
        end
        wr_en = 1'b0;
        repeat (15) tick();
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rm_bit3: got %b expected 0", tx); end
        rst = 1'b1;
        tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rm_tx: got %b expected 1", tx); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_ovf: got %b expected 0", overflow); end
        tick();
        rst = 1'b0;
        rx_q.delete(); st_q.delete();
        repeat (200) tick();
        checks++; if (st_q.size() != 0) begin errors++; $display("FAIL rm_no_frames: got %0d starts expected 0", st_q.size()); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rm_idle_tx: got %b expected 1", tx); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rm_empty: got %b expected 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_collision();
        test_full_pop();
        checks++; if (frame_err != 0) begin errors++; $display("FAIL frame_format: got %0d bad frames expected 0", frame_err); end
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_io.md
Name: uart_tx_io

Overview:
Memory-mapped UART transmitter peripheral. It is the outbound counterpart to the UART programming receiver, and lets the CPU send bytes out on the tx pin through MEM_IO. CPU stores enqueue bytes into a small FIFO. An 8N1 serializer drains the FIFO at a fixed baud divisor, and status flags are readable by CPU loads.

Parameters:
CLKS_PER_BIT, 87, clk cycles per serial bit (10 MHz / 115200 ≈ 87); legal range ≥ 2.
FIFO_DEPTH, 8, transmit FIFO entries; must be a power of 2, ≥ 2.
CW, $clog2(FIFO_DEPTH)+1, width of the fill count (derived; not overridable).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
wr_en  in  1  CPU store strobe; one byte enqueued per cycle asserted.
wr_data  in  8  byte to enqueue.
clr_ovf  in  1  clears the overflow flag.
tx  out  1  serial line; idle high.
busy  out  1  FSM not IDLE, or FIFO non-empty.
full  out  1  count == FIFO_DEPTH.
empty  out  1  count == 0.
overflow  out  1  sticky: a write was dropped.
count  out  CW  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge): tx=1, state=IDLE, baud counter=0, bit index=0, FIFO read/write pointers=0, count=0, overflow=0. Outputs after reset: busy=0, full=0, empty=1.
- Reset mid-frame: the line returns high on the same edge. The partial frame is abandoned and all queued bytes are discarded.
- FIFO storage and pointers:
  - Circular buffer with log2(FIFO_DEPTH)-bit pointers that wrap naturally.
  - count is a separate register, updated as +1 (write only), −1 (pop only), or unchanged (both or neither).
- Write acceptance:
  - A write is accepted iff wr_en=1 and full=0, judged on the pre-edge count.
  - A write while full is dropped and sets overflow=1, even if a pop occurs in the same cycle.
  - Simultaneous write and pop at count=1 leaves count=1, and the written byte is retained.
- Overflow flag: sticky until clr_ovf=1 or rst. If clr_ovf and a dropped write coincide, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - tx is a registered output.
  - One baud counter runs 0..CLKS_PER_BIT−1. Each bit is held exactly CLKS_PER_BIT cycles.
- IDLE: tx=1.
  - If FIFO is non-empty: pop the head into a shift register, clear the baud counter, go to START.
  - Pop and START entry occur on the same edge, so tx=0 from that edge.
- START: tx=0. At baud counter = CLKS_PER_BIT−1, go to DATA with bit index 0.
- DATA: tx=shift[0], LSB first.
  - At each bit end, shift right and increment the bit index.
  - After bit 7 ends, go to STOP.
- STOP: tx=1. At bit end, go to IDLE.
- Timing:
  - A frame is 10×CLKS_PER_BIT cycles.
  - Back-to-back frames carry exactly 1 extra idle-high cycle (the IDLE cycle) between the stop bit and the next start bit.
- Latency: a write at edge N into an empty FIFO with FSM in IDLE gives a pop at edge N+1, and tx falls at edge N+1.
- busy deasserts on the edge the FSM enters IDLE with an empty FIFO.
- Writes during transmission never disturb the frame in flight.

Test Plan:
- Single byte, CLKS_PER_BIT=4: write 0xA5 → tx falls 1 cycle later. Per 4-cycle bit, the line sequence is 0,1,0,1,0,0,1,0,1,1. busy=1 throughout and drops after 40 cycles of frame.
- Back-to-back: write 0x00, 0xFF, 0x3C on consecutive cycles → count peaks at 2 and three frames are emitted in order. Each gap between a stop bit and the next start bit is exactly 1 extra high cycle. Final state: empty=1, busy=0.
- Overflow, FIFO_DEPTH=8: 10 consecutive writes while idle → 1 byte is popped immediately, 8 are queued, 1 is dropped; full=1 and overflow=1. Pulsing clr_ovf clears overflow. 9 frames are emitted in total.
- Write+pop collision: hold count=1 in IDLE and write on the pop cycle → count stays 1 and both bytes are transmitted in order.
- Write while full with pop: full FIFO, FSM pops on the same edge as wr_en → the write is dropped, overflow=1, count=7.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1 on that edge, count=0, busy=0, and no further frames are emitted.
